// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA timing generator: prefetches RGB565 words
// over a single-outstanding read bus into a FIFO and streams them out with syncs aligned.
module vga_pixel_fetch #(
  parameter int ADDR_WIDTH = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_visible,
  input  logic                  i_hSync,
  input  logic                  i_vSync,
  input  logic                  i_inth,
  input  logic                  i_intv,
  input  logic [ADDR_WIDTH-1:0] i_fbBase,
  input  logic [ADDR_WIDTH-1:0] i_frameWords,
  input  logic                  i_clrUnderflow,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rd,
  input  logic [15:0]           i_data,
  input  logic                  i_ack,
  output logic [4:0]            o_r,
  output logic [5:0]            o_g,
  output logic [4:0]            o_b,
  output logic                  o_de,
  output logic                  o_hSync,
  output logic                  o_vSync,
  output logic                  o_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t           state;
  fetchState_t           stateNext;
  logic                  rdReg;
  logic [ADDR_WIDTH-1:0] busAddr;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic [ADDR_WIDTH-1:0] fetched;
  logic                  pushEn;

  logic [15:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [PTR_W:0]        fifoCount;

  logic [15:0]           pixReg;
  logic                  deReg;
  logic                  hSyncReg;
  logic                  vSyncReg;
  logic                  underflowReg;

  logic                  frameStart;
  logic                  fifoEmpty;
  logic                  popEn;

  assign frameStart = i_inth && i_intv;
  assign fifoEmpty  = (fifoCount == '0);
  assign popEn      = i_visible && !fifoEmpty && !frameStart;

  // Fetch FSM next-state decode; a frame start turns any in-flight read into a discard.
  always_comb begin
    stateNext = state;
    pushEn    = 1'b0;
    case (state)
      IDLE: begin
        if (!frameStart && (fetched < i_frameWords) && (fifoCount < DEPTH_CNT)) begin
          stateNext = REQ;
        end else begin
          stateNext = IDLE;
        end
      end
      REQ: begin
        if (i_ack) begin
          stateNext = IDLE;
          pushEn    = !frameStart;
        end else if (frameStart) begin
          stateNext = DISCARD;
        end else begin
          stateNext = REQ;
        end
      end
      DISCARD: begin
        if (i_ack) begin
          stateNext = IDLE;
        end else begin
          stateNext = DISCARD;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Fetch state, bus request and address bookkeeping; o_addr only loads when a request starts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      rdReg     <= 1'b0;
      busAddr   <= i_fbBase;
      fetchAddr <= i_fbBase;
      fetched   <= '0;
    end else begin
      state <= stateNext;
      rdReg <= (stateNext != IDLE);
      if ((state == IDLE) && (stateNext == REQ)) begin
        busAddr <= fetchAddr;
      end
      if (frameStart) begin
        fetchAddr <= i_fbBase;
        fetched   <= '0;
      end else if (pushEn) begin
        fetchAddr <= fetchAddr + ADDR_WIDTH'(1);
        fetched   <= fetched + ADDR_WIDTH'(1);
      end
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (pushEn) begin
      mem[wrPtr] <= i_data;
    end
  end

  // FIFO pointers and occupancy, flushed on frame start.
  always_ff @(posedge i_clk) begin
    if (i_reset || frameStart) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushEn, popEn})
        2'b10:   fifoCount <= fifoCount + (PTR_W + 1)'(1);
        2'b01:   fifoCount <= fifoCount - (PTR_W + 1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Pixel output stage and sticky underflow; setting takes priority over clearing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pixReg       <= 16'h0000;
      deReg        <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      deReg  <= i_visible;
      pixReg <= popEn ? mem[rdPtr] : 16'h0000;
      if (i_visible && fifoEmpty) begin
        underflowReg <= 1'b1;
      end else if (i_clrUnderflow) begin
        underflowReg <= 1'b0;
      end
    end
  end

  // Sync delay matching the one-cycle colour pipeline, also during reset.
  always_ff @(posedge i_clk) begin
    hSyncReg <= i_hSync;
    vSyncReg <= i_vSync;
  end

  assign o_rd        = rdReg;
  assign o_addr      = busAddr;
  assign o_r         = pixReg[15:11];
  assign o_g         = pixReg[10:5];
  assign o_b         = pixReg[4:0];
  assign o_de        = deReg;
  assign o_hSync     = hSyncReg;
  assign o_vSync     = vSyncReg;
  assign o_underflow = underflowReg;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised and directed bench for vga_pixel_fetch against a queue-based
// model of the framebuffer stream and bus protocol.
module tb_vga_pixel_fetch;
  localparam int AW    = 18;
  localparam int DEPTH = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_visible = 1'b0, i_hSync = 1'b0, i_vSync = 1'b0;
  logic          i_inth = 1'b0, i_intv = 1'b0;
  logic [AW-1:0] i_fbBase = '0, i_frameWords = '0;
  logic          i_clrUnderflow = 1'b0;
  logic [AW-1:0] o_addr;
  logic          o_rd;
  logic [15:0]   i_data = 16'h0000;
  logic          i_ack = 1'b0;
  logic [4:0]    o_r;
  logic [5:0]    o_g;
  logic [4:0]    o_b;
  logic          o_de, o_hSync, o_vSync, o_underflow;

  vga_pixel_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_visible(i_visible),
    .i_hSync(i_hSync), .i_vSync(i_vSync), .i_inth(i_inth), .i_intv(i_intv),
    .i_fbBase(i_fbBase), .i_frameWords(i_frameWords),
    .i_clrUnderflow(i_clrUnderflow), .o_addr(o_addr), .o_rd(o_rd),
    .i_data(i_data), .i_ack(i_ack), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_de(o_de), .o_hSync(o_hSync), .o_vSync(o_vSync), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0]   mq[$];
  logic [AW-1:0] mAddr = '0;
  int            mFetched = 0;
  bit            mUf = 1'b0;
  bit            tainted = 1'b0;
  bit            prevRd = 1'b0;
  logic [AW-1:0] prevAddr = '0;
  bit            shouldFetch = 1'b0;

  // bus slave state
  int            ackDelay = 0;
  int            waitCnt = 0;
  bit            slaveBusy = 1'b0;
  logic [15:0]   dataQ[$];
  logic [AW-1:0] reqLog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit vis, input bit fs, input bit clr);
    logic        hs, vs, ack;
    logic [15:0] d;
    logic [15:0] expPix;
    bit          empty;
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    ack = 1'b0;
    d   = 16'($urandom);
    if (o_rd && !rst) begin
      if (!slaveBusy) begin
        slaveBusy = 1'b1;
        waitCnt   = ackDelay;
      end
      if (waitCnt == 0) begin
        ack = 1'b1;
        if (dataQ.size() > 0) d = dataQ.pop_front();
      end else begin
        waitCnt--;
      end
    end
    i_reset        = rst;
    i_visible      = vis;
    i_inth         = fs ? 1'b1 : ($urandom_range(0, 3) == 0);
    i_intv         = fs ? 1'b1 : (i_inth ? 1'b0 : 1'($urandom));
    i_hSync        = hs;
    i_vSync        = vs;
    i_clrUnderflow = clr;
    i_ack          = ack;
    i_data         = d;
    @(posedge i_clk);
    #1;
    if (ack || rst) slaveBusy = 1'b0;
    check("hSync", 32'(o_hSync), 32'(hs));
    check("vSync", 32'(o_vSync), 32'(vs));
    if (rst) begin
      mq.delete();
      mAddr = i_fbBase;
      mFetched = 0;
      mUf = 1'b0;
      tainted = 1'b0;
      check("rstRd", 32'(o_rd), 32'd0);
      check("rstAddr", 32'(o_addr), 32'(i_fbBase));
      check("rstPix", 32'({o_r, o_g, o_b}), 32'd0);
      check("rstDe", 32'(o_de), 32'd0);
      check("rstUf", 32'(o_underflow), 32'd0);
    end else begin
      empty = (mq.size() == 0);
      if (!fs && vis && !empty) expPix = mq.pop_front();
      else expPix = 16'h0000;
      if (vis && empty) mUf = 1'b1;
      else if (clr) mUf = 1'b0;
      if (prevRd && ack && !(tainted || fs)) begin
        mq.push_back(d);
        mFetched++;
        mAddr = mAddr + AW'(1);
      end
      if (prevRd && fs) tainted = 1'b1;
      if (fs) begin
        mq.delete();
        mFetched = 0;
        mAddr = i_fbBase;
      end
      check("pixel", 32'({o_r, o_g, o_b}), 32'(expPix));
      check("de", 32'(o_de), 32'(vis));
      check("underflow", 32'(o_underflow), 32'(mUf));
      if (prevRd && ack) begin
        check("rdDropAfterAck", 32'(o_rd), 32'd0);
      end else if (prevRd) begin
        check("rdHeld", 32'(o_rd), 32'd1);
        check("addrHeld", 32'(o_addr), 32'(prevAddr));
      end else begin
        check("reqStart", 32'(o_rd), 32'(shouldFetch && !fs));
        if (o_rd) begin
          check("reqAddr", 32'(o_addr), 32'(mAddr));
          tainted = 1'b0;
          reqLog.push_back(o_addr);
        end
      end
    end
    shouldFetch = !o_rd && (mFetched < int'(i_frameWords)) && (mq.size() < DEPTH);
    prevRd   = o_rd;
    prevAddr = o_addr;
  endtask

  task automatic doReset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] expAddrs[4];
    int fsCnt;

    // basic fetch: four words from 0x100 with a two-cycle slave
    i_fbBase = AW'(18'h100);
    i_frameWords = AW'(4);
    ackDelay = 2;
    doReset();
    reqLog.delete();
    idle(30);
    check("t1ReqCount", 32'(reqLog.size()), 32'd4);
    expAddrs = '{18'h100, 18'h101, 18'h102, 18'h103};
    for (int k = 0; k < 4; k++)
      if (k < reqLog.size()) check("t1Addr", 32'(reqLog[k]), 32'(expAddrs[k]));
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1NoUfYet", 32'(o_underflow), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1UfAfter4", 32'(o_underflow), 32'd1);

    // colour decode and underflow set/clear priority
    i_fbBase = AW'(18'h40);
    i_frameWords = AW'(3);
    ackDelay = 1;
    doReset();
    dataQ.delete();
    dataQ.push_back(16'hF800);
    dataQ.push_back(16'h07E0);
    dataQ.push_back(16'h001F);
    idle(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("redR", 32'(o_r), 32'd31); check("redG", 32'(o_g), 32'd0); check("redB", 32'(o_b), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("grnR", 32'(o_r), 32'd0); check("grnG", 32'(o_g), 32'd63); check("grnB", 32'(o_b), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("bluR", 32'(o_r), 32'd0); check("bluG", 32'(o_g), 32'd0); check("bluB", 32'(o_b), 32'd31);
    check("bluDe", 32'(o_de), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("emptyDe", 32'(o_de), 32'd1);
    check("emptyPix", 32'({o_r, o_g, o_b}), 32'd0);
    check("emptyUf", 32'(o_underflow), 32'd1);
    idle(3);
    check("ufSticky", 32'(o_underflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("ufCleared", 32'(o_underflow), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("ufSetWins", 32'(o_underflow), 32'd1);

    // frame start during a slow read: data dropped, refetch from new base
    i_fbBase = AW'(18'h200);
    i_frameWords = AW'(8);
    ackDelay = 20;
    doReset();
    reqLog.delete();
    idle(6);
    i_fbBase = AW'(18'h300);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    check("t3ReqCount>=2", 32'(reqLog.size() >= 2), 32'd1);
    if (reqLog.size() >= 2) begin
      check("t3FirstAddr", 32'(reqLog[0]), 32'h200);
      check("t3AfterFs", 32'(reqLog[1]), 32'h300);
    end

    // FIFO fill limit with an immediate slave, then one pop frees one fetch
    i_fbBase = AW'(0);
    i_frameWords = AW'(100);
    ackDelay = 0;
    doReset();
    reqLog.delete();
    idle(60);
    check("fillCount", 32'(reqLog.size()), 32'd16);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    check("refillCount", 32'(reqLog.size()), 32'd17);

    // zero-length frame, then address wrap
    i_frameWords = AW'(0);
    doReset();
    reqLog.delete();
    idle(20);
    check("zeroWords", 32'(reqLog.size()), 32'd0);
    i_fbBase = AW'(18'h3FFFE);
    i_frameWords = AW'(4);
    doReset();
    reqLog.delete();
    idle(20);
    check("wrapCount", 32'(reqLog.size()), 32'd4);
    expAddrs = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    for (int k = 0; k < 4; k++)
      if (k < reqLog.size()) check("wrapAddr", 32'(reqLog[k]), 32'(expAddrs[k]));

    // random traffic with periodic frame starts and occasional resets
    fsCnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rst, fs, vis, clr;
      fsCnt++;
      fs  = (fsCnt >= 90 + int'($urandom_range(0, 30)));
      if (fs) begin
        fsCnt = 0;
        ackDelay = $urandom_range(0, 4);
        i_fbBase = AW'($urandom);
        i_frameWords = AW'($urandom_range(0, 40));
      end
      rst = ($urandom_range(0, 299) == 0);
      vis = !fs && ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 19) == 0);
      cycle(rst, vis, fs, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
